memory_mmio: RTL and testbench
==============================

# memory_mmio

Parametrised data memory for the RISC-V core with a memory-mapped I/O window. It supports byte/halfword/word (and doubleword when WIDTH=64) loads and stores selected by `funct3`, a registered one-cycle read path with a valid strobe, and misalignment detection. It also provides NUM_OUTPORTS writable/readable output registers and NUM_INPORTS sampled input registers. It sits between the core's load/store unit and the board I/O, and keeps the `flash_en` preload path for program/data initialisation.

## Interface
- WIDTH, 32: data/address width; 32 or 64 only.
- DEPTH_WORDS, 256: RAM depth in WIDTH-bit words; power of two.
- NUM_OUTPORTS, 2: number of output registers, 1..8.
- NUM_INPORTS, 1: number of input registers, 0..8.
- IO_BASE, 'hFFF0 (zero-extended): byte address of the I/O window; WIDTH/8-aligned.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  WIDTH  byte address.
- rd_en  in  1  load request.
- wren  in  1  store request.
- wr_data  in  WIDTH  store data, right-justified.
- funct3  in  funct3_t  access size/sign (LOAD_STORE_FNS encodings).
- flash_en  in  1  preload: full-word write of wr_data at addr.
- rd_data  out  WIDTH  registered load result.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- misalign  out  1  one-cycle pulse, faulting access.
- outport  out  NUM_OUTPORTS x WIDTH  output registers.
- inport  in  NUM_INPORTS x WIDTH  asynchronous external inputs.

## Operation
- Little-endian, byte-addressed. RAM word index = addr[log2(WIDTH/8) +: log2(DEPTH_WORDS)], used only when addr < DEPTH_WORDS*WIDTH/8.
- Address map: outport k at IO_BASE + k*WIDTH/8. Inport j at IO_BASE + (NUM_OUTPORTS+j)*WIDTH/8. Any other I/O address, and any address outside both RAM and I/O: reads return 0, writes are ignored, no fault.
- funct3: 000 B, 001 H, 010 W, 011 D (WIDTH=64 only), 100 BU, 101 HU, 110 WU (WIDTH=64 only). Signed forms sign-extend; U forms zero-extend. Stores use the low bits of funct3 (000/001/010/011).
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0. An unsupported encoding is treated as a fault.
- A fault on a store suppresses the write. A fault on a load returns rd_data=0 with rd_valid=1. In both cases misalign=1 for one cycle.
- Stores are byte-enabled: only the addressed lanes change. This applies to outports too; sub-word stores merge into the outport register.
- Outports read back their current value. Inports are captured into a register every cycle (1-stage); a load returns the captured value.
- flash_en writes the full wr_data word at the word index, ignoring funct3 and addr low bits. It never faults. It writes RAM only, never I/O.

## Timing
- Reset values: rd_data=0, rd_valid=0, misalign=0, outport[*]=0, inport capture=0. RAM contents are NOT cleared.
- While rst=1: flash_en writes still take effect (preload is performed under reset). wren and rd_en are ignored.
- Load latency is 1: with rd_en sampled at edge N, rd_data and rd_valid are valid after edge N; rd_valid deasserts after edge N+1 unless rd_en is held. rd_data holds its value when rd_valid=0.
- Store: the RAM/outport update is visible at edge N (outport visible immediately after the edge).
- rd_en and wren in the same cycle at the same address: the read returns the pre-write data.
- flash_en and wren in the same cycle: the flash write wins and the store is dropped (no fault).
- Reset asserted mid-load clears rd_valid and rd_data immediately; the pending load is lost.
- Inport change to load result: 2 edges (capture, then read).

## Test plan
- Under rst=1, flash 12345@0, 678910@4, 'hFFFFFFFF@12. Release reset, then LW each address -> rd_data matches and rd_valid pulses once, 1 cycle after rd_en.
- SB 'h80@5, then LB@5 -> 'hFFFFFF80; LBU@5 -> 'h00000080. LW@4 -> 678910 with byte 1 replaced by 'h80.
- SH 'hBEEF@10, then LHU@10 -> 'h0000BEEF; LH@10 -> 'hFFFFBEEF. LW@8 has the low half unchanged.
- LW@2 -> misalign pulse, rd_data=0, rd_valid=1. SH@7 -> misalign pulse, and a later LW@4 is unchanged.
- SW 'hDEADBEEF to outport0, then SB 'h11 to IO_BASE+4 -> outport0='hDEADBEEF, outport1='h00000011. LW outport0 reads back 'hDEADBEEF. Asserting rst -> both outports read 0.
- Drive inport0='hCAFE0001, then LW at IO_BASE+8 -> 'hCAFE0001. flash_en and wren same cycle at @8 with differing wr_data -> the flash value is stored.

Source files
------------

// File: rtl/memory_mmio.sv
// rtl/memory_mmio.sv - data memory with byte-enabled load/store and memory-mapped I/O window
module memory_mmio #(
   parameter int          WIDTH        = 32,
   parameter int          DEPTH_WORDS  = 256,
   parameter int          NUM_OUTPORTS = 2,
   parameter int          NUM_INPORTS  = 1,
   parameter logic [63:0] IO_BASE      = 64'hFFF0
) (
   input  logic                                                     i_clk,
   input  logic                                                     i_rst,
   input  logic [WIDTH-1:0]                                         i_addr,
   input  logic                                                     i_rd_en,
   input  logic                                                     i_wren,
   input  logic [WIDTH-1:0]                                         i_wr_data,
   input  logic [2:0]                                               i_funct3,
   input  logic                                                     i_flash_en,
   output logic [WIDTH-1:0]                                         o_rd_data,
   output logic                                                     o_rd_valid,
   output logic                                                     o_misalign,
   output logic [NUM_OUTPORTS-1:0][WIDTH-1:0]                       o_outport,
   input  logic [((NUM_INPORTS > 0) ? NUM_INPORTS : 1)-1:0][WIDTH-1:0] i_inport
);

   localparam int NB     = WIDTH / 8;
   localparam int OFFB   = $clog2(NB);
   localparam int AW     = $clog2(DEPTH_WORDS);
   localparam int NIN    = (NUM_INPORTS > 0) ? NUM_INPORTS : 1;
   localparam int NPORTS = NUM_OUTPORTS + NUM_INPORTS;
   localparam logic [WIDTH-1:0] IO_B = IO_BASE[WIDTH-1:0];

   logic [WIDTH-1:0]                    r_mem [DEPTH_WORDS];
   logic [NUM_OUTPORTS-1:0][WIDTH-1:0]  r_outport;
   logic [NIN-1:0][WIDTH-1:0]           r_inport;

   logic [OFFB-1:0]   w_off;
   logic [OFFB+2:0]   w_shamt;
   logic [AW-1:0]     w_widx;
   logic              w_ram_hit;
   logic [WIDTH-1:0]  w_io_word;
   logic              w_io_hit;
   logic [4:0]        w_io_idx;
   logic              w_ld_enc_ok;
   logic              w_st_enc_ok;
   logic              w_align_ok;
   logic              w_ld_fault;
   logic              w_st_fault;
   logic              w_do_store;
   logic              w_fault_ev;
   logic [7:0]        w_mask8;
   logic [NB-1:0]     w_be;
   logic [WIDTH-1:0]  w_wshift;
   logic [WIDTH-1:0]  w_rword;
   logic [WIDTH-1:0]  w_rshift;
   logic [WIDTH-1:0]  w_keep;
   logic              w_sbit;
   logic [WIDTH-1:0]  w_ldata;

   assign o_outport = r_outport;

   // Lane-wise merge of new store data into an existing word.
   function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_w,
                                                input logic [WIDTH-1:0] new_w,
                                                input logic [NB-1:0]    be);
      logic [WIDTH-1:0] res;
      for (int b = 0; b < NB; b++) begin
         res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      end
      return res;
   endfunction

   // Address decode: RAM hit, I/O window slot, byte offset and word index.
   always_comb begin
      w_off     = i_addr[OFFB-1:0];
      w_shamt   = {w_off, 3'b000};
      w_widx    = i_addr[OFFB +: AW];
      w_ram_hit = ((i_addr >> (OFFB + AW)) == '0);
      w_io_word = (i_addr - IO_B) >> OFFB;
      w_io_hit  = !w_ram_hit && (i_addr >= IO_B) && (w_io_word < WIDTH'(NPORTS));
      w_io_idx  = w_io_word[4:0];
   end

   // Access size legality, alignment and the resulting fault/store qualifiers.
   always_comb begin
      w_ld_enc_ok = 1'b0;
      case (i_funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ld_enc_ok = 1'b1;
         3'b011, 3'b110:                         w_ld_enc_ok = (WIDTH == 64);
         default:                                w_ld_enc_ok = 1'b0;
      endcase
      w_st_enc_ok = (i_funct3[1:0] != 2'b11) || (WIDTH == 64);
      w_align_ok  = 1'b1;
      case (i_funct3[1:0])
         2'b00:   w_align_ok = 1'b1;
         2'b01:   w_align_ok = !i_addr[0];
         2'b10:   w_align_ok = (i_addr[1:0] == 2'b00);
         default: w_align_ok = (i_addr[2:0] == 3'b000);
      endcase
      w_ld_fault = !w_ld_enc_ok || !w_align_ok;
      w_st_fault = !w_st_enc_ok || !w_align_ok;
      // flash preload pre-empts a concurrent store, which then neither writes nor faults
      w_do_store = i_wren && !i_flash_en && !w_st_fault;
      w_fault_ev = (i_rd_en && w_ld_fault) || (i_wren && !i_flash_en && w_st_fault);
   end

   // Store lane enables and data shifted into the addressed lanes.
   always_comb begin
      w_mask8 = 8'h00;
      case (i_funct3[1:0])
         2'b00:   w_mask8 = 8'h01;
         2'b01:   w_mask8 = 8'h03;
         2'b10:   w_mask8 = 8'h0F;
         default: w_mask8 = 8'hFF;
      endcase
      w_be     = NB'(w_mask8 << w_off);
      w_wshift = i_wr_data << w_shamt;
   end

   // Read mux over RAM, outports and captured inports, then size/sign extraction.
   always_comb begin
      w_rword = '0;
      if (w_ram_hit) begin
         w_rword = r_mem[w_widx];
      end else if (w_io_hit) begin
         for (int k = 0; k < NUM_OUTPORTS; k++) begin
            if (w_io_idx == 5'(k)) w_rword = r_outport[k];
         end
         for (int j = 0; j < NUM_INPORTS; j++) begin
            if (w_io_idx == 5'(NUM_OUTPORTS + j)) w_rword = r_inport[j];
         end
      end
      w_rshift = w_rword >> w_shamt;
      w_keep   = '1;
      w_sbit   = 1'b0;
      case (i_funct3[1:0])
         2'b00: begin w_keep = WIDTH'(8'hFF);         w_sbit = w_rshift[7];  end
         2'b01: begin w_keep = WIDTH'(16'hFFFF);      w_sbit = w_rshift[15]; end
         2'b10: begin w_keep = WIDTH'(32'hFFFF_FFFF); w_sbit = w_rshift[31]; end
         default: begin w_keep = '1;                  w_sbit = 1'b0;         end
      endcase
      w_ldata = (w_rshift & w_keep) | ((!i_funct3[2] && w_sbit) ? ~w_keep : '0);
   end

   // RAM array: flash preload works even under reset; stores only outside reset.
   always_ff @(posedge i_clk) begin
      if (i_flash_en && w_ram_hit) begin
         r_mem[w_widx] <= i_wr_data;
      end else if (!i_rst && w_do_store && w_ram_hit) begin
         r_mem[w_widx] <= f_merge(r_mem[w_widx], w_wshift, w_be);
      end
   end

   // Registered load result, valid strobe and fault strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_rd_data  <= '0;
         o_rd_valid <= 1'b0;
         o_misalign <= 1'b0;
      end else begin
         o_rd_valid <= i_rd_en;
         o_misalign <= w_fault_ev;
         if (i_rd_en) o_rd_data <= w_ld_fault ? '0 : w_ldata;
      end
   end

   // Output registers with byte-enabled merge of sub-word stores.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_outport <= '0;
      end else if (w_do_store && w_io_hit) begin
         for (int k = 0; k < NUM_OUTPORTS; k++) begin
            if (w_io_idx == 5'(k)) r_outport[k] <= f_merge(r_outport[k], w_wshift, w_be);
         end
      end
   end

   // Single-stage capture of the asynchronous external inputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_inport <= '0;
      end else begin
         r_inport <= i_inport;
      end
   end

endmodule

// File: tb/tb_memory_mmio.sv
// tb/tb_memory_mmio.sv - directed self-checking bench for memory_mmio
module tb_memory_mmio;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;
   localparam logic [2:0] F_WU = 3'b110;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      addr;
   logic             rd_en;
   logic             wren;
   logic [31:0]      wr_data;
   logic [2:0]       funct3;
   logic             flash_en;
   logic [31:0]      rd_data;
   logic             rd_valid;
   logic             misalign;
   logic [1:0][31:0] outport;
   logic [0:0][31:0] inport;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   memory_mmio dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_addr     (addr),
      .i_rd_en    (rd_en),
      .i_wren     (wren),
      .i_wr_data  (wr_data),
      .i_funct3   (funct3),
      .i_flash_en (flash_en),
      .o_rd_data  (rd_data),
      .o_rd_valid (rd_valid),
      .o_misalign (misalign),
      .o_outport  (outport),
      .i_inport   (inport)
   );

   // One-cycle operation: drive, take one rising edge, sample 1 time unit later.
   task automatic drive(input logic rd, input logic wr, input logic fl,
                        input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      rd_en = rd; wren = wr; flash_en = fl; addr = a; wr_data = d; funct3 = f;
      @(posedge clk); #1;
      rd_en = 1'b0; wren = 1'b0; flash_en = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
      total++; if (outport !== 64'h0) begin bad++; $display("FAIL reset_outport got=%h exp=0", outport); end
   endtask

   task automatic test_preload();
      drive(0, 0, 1, 32'd0,  32'd12345,     F_W);
      drive(0, 0, 1, 32'd4,  32'd678910,    F_W);
      drive(0, 0, 1, 32'd12, 32'hFFFF_FFFF, F_W);
      drive(0, 0, 1, 32'd8,  32'h1122_3344, F_W);
      drive(0, 1, 0, 32'd0,  32'h0000_0BAD, F_W);
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_ignored got=%b exp=0", rd_valid); end
      rst = 1'b0;
      drive(1, 0, 0, 32'd0, 32'h0, F_W);
      total++; if (rd_data !== 32'd12345) begin bad++; $display("FAIL lw0 got=%h exp=%h", rd_data, 32'd12345); end
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL lw0_valid got=%b exp=1", rd_valid); end
      @(posedge clk); #1;
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL lw0_valid_drop got=%b exp=0", rd_valid); end
      total++; if (rd_data !== 32'd12345) begin bad++; $display("FAIL lw0_hold got=%h exp=%h", rd_data, 32'd12345); end
      drive(1, 0, 0, 32'd4, 32'h0, F_W);
      total++; if (rd_data !== 32'h000A_5BFE) begin bad++; $display("FAIL lw4 got=%h exp=%h", rd_data, 32'h000A_5BFE); end
      drive(1, 0, 0, 32'd12, 32'h0, F_W);
      total++; if (rd_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL lw12 got=%h exp=%h", rd_data, 32'hFFFF_FFFF); end
   endtask

   task automatic test_byte();
      drive(0, 1, 0, 32'd5, 32'h0000_0080, F_B);
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL sb5_fault got=%b exp=0", misalign); end
      drive(1, 0, 0, 32'd5, 32'h0, F_B);
      total++; if (rd_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb5 got=%h exp=%h", rd_data, 32'hFFFF_FF80); end
      drive(1, 0, 0, 32'd5, 32'h0, F_BU);
      total++; if (rd_data !== 32'h0000_0080) begin bad++; $display("FAIL lbu5 got=%h exp=%h", rd_data, 32'h0000_0080); end
      drive(1, 0, 0, 32'd4, 32'h0, F_W);
      total++; if (rd_data !== 32'h000A_80FE) begin bad++; $display("FAIL lw4_after_sb got=%h exp=%h", rd_data, 32'h000A_80FE); end
   endtask

   task automatic test_half();
      drive(0, 1, 0, 32'd10, 32'h0000_BEEF, F_H);
      drive(1, 0, 0, 32'd10, 32'h0, F_HU);
      total++; if (rd_data !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu10 got=%h exp=%h", rd_data, 32'h0000_BEEF); end
      drive(1, 0, 0, 32'd10, 32'h0, F_H);
      total++; if (rd_data !== 32'hFFFF_BEEF) begin bad++; $display("FAIL lh10 got=%h exp=%h", rd_data, 32'hFFFF_BEEF); end
      drive(1, 0, 0, 32'd8, 32'h0, F_W);
      total++; if (rd_data !== 32'hBEEF_3344) begin bad++; $display("FAIL lw8_after_sh got=%h exp=%h", rd_data, 32'hBEEF_3344); end
   endtask

   task automatic test_misalign();
      drive(1, 0, 0, 32'd2, 32'h0, F_W);
      total++; if (misalign !== 1'b1) begin bad++; $display("FAIL lw2_fault got=%b exp=1", misalign); end
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL lw2_valid got=%b exp=1", rd_valid); end
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL lw2_data got=%h exp=0", rd_data); end
      @(posedge clk); #1;
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL lw2_fault_pulse got=%b exp=0", misalign); end
      drive(0, 1, 0, 32'd7, 32'h0000_1234, F_H);
      total++; if (misalign !== 1'b1) begin bad++; $display("FAIL sh7_fault got=%b exp=1", misalign); end
      drive(1, 0, 0, 32'd4, 32'h0, F_W);
      total++; if (rd_data !== 32'h000A_80FE) begin bad++; $display("FAIL lw4_after_sh7 got=%h exp=%h", rd_data, 32'h000A_80FE); end
      drive(1, 0, 0, 32'd0, 32'h0, F_WU);
      total++; if (misalign !== 1'b1) begin bad++; $display("FAIL lwu_fault got=%b exp=1", misalign); end
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL lwu_data got=%h exp=0", rd_data); end
   endtask

   task automatic test_outport();
      drive(0, 1, 0, 32'hFFF0, 32'hDEAD_BEEF, F_W);
      drive(0, 1, 0, 32'hFFF4, 32'h0000_0011, F_B);
      total++; if (outport[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL outport0 got=%h exp=%h", outport[0], 32'hDEAD_BEEF); end
      total++; if (outport[1] !== 32'h0000_0011) begin bad++; $display("FAIL outport1 got=%h exp=%h", outport[1], 32'h0000_0011); end
      drive(1, 0, 0, 32'hFFF0, 32'h0, F_W);
      total++; if (rd_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_outport0 got=%h exp=%h", rd_data, 32'hDEAD_BEEF); end
      drive(0, 1, 0, 32'hFFF1, 32'h0000_0022, F_B);
      total++; if (outport[0] !== 32'hDEAD_22EF) begin bad++; $display("FAIL sb_outport0_merge got=%h exp=%h", outport[0], 32'hDEAD_22EF); end
      drive(1, 0, 0, 32'hFFFC, 32'h0, F_W);
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL lw_unmapped_io got=%h exp=0", rd_data); end
      drive(0, 1, 0, 32'h2000, 32'h1234_5678, F_W);
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL sw_unmapped_fault got=%b exp=0", misalign); end
      drive(1, 0, 0, 32'h2000, 32'h0, F_W);
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL lw_unmapped got=%h exp=0", rd_data); end
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (outport !== 64'h0) begin bad++; $display("FAIL outport_reset got=%h exp=0", outport); end
      rst = 1'b0;
   endtask

   task automatic test_inport();
      inport[0] = 32'hCAFE_0001;
      @(posedge clk); #1;
      drive(1, 0, 0, 32'hFFF8, 32'h0, F_W);
      total++; if (rd_data !== 32'hCAFE_0001) begin bad++; $display("FAIL lw_inport got=%h exp=%h", rd_data, 32'hCAFE_0001); end
      drive(0, 1, 0, 32'hFFF8, 32'h0, F_W);
      drive(1, 0, 0, 32'hFFF8, 32'h0, F_HU);
      total++; if (rd_data !== 32'h0000_0001) begin bad++; $display("FAIL lhu_inport got=%h exp=%h", rd_data, 32'h0000_0001); end
   endtask

   task automatic test_flash_wins();
      drive(0, 1, 1, 32'd9, 32'h5566_7788, F_H);
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL flash_wren_fault got=%b exp=0", misalign); end
      drive(1, 0, 0, 32'd8, 32'h0, F_W);
      total++; if (rd_data !== 32'h5566_7788) begin bad++; $display("FAIL flash_wins got=%h exp=%h", rd_data, 32'h5566_7788); end
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 0, 32'd0, 32'hA5A5_A5A5, F_W);
      total++; if (rd_data !== 32'd12345) begin bad++; $display("FAIL rdw_old got=%h exp=%h", rd_data, 32'd12345); end
      rd_en = 1'b1; addr = 32'd0; funct3 = F_W;
      @(posedge clk); #1;
      total++; if (rd_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL b2b_first got=%h exp=%h", rd_data, 32'hA5A5_A5A5); end
      addr = 32'd4;
      @(posedge clk); #1;
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", rd_valid); end
      total++; if (rd_data !== 32'h000A_80FE) begin bad++; $display("FAIL b2b_second got=%h exp=%h", rd_data, 32'h000A_80FE); end
      rd_en = 1'b0;
   endtask

   task automatic test_reset_midload();
      drive(1, 0, 0, 32'd12, 32'h0, F_W);
      total++; if (rd_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL midload_pre got=%h exp=%h", rd_data, 32'hFFFF_FFFF); end
      rst = 1'b1;
      #1;
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midload_valid got=%b exp=0", rd_valid); end
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL midload_data got=%h exp=0", rd_data); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; addr = '0; rd_en = 1'b0; wren = 1'b0; wr_data = '0;
      funct3 = F_W; flash_en = 1'b0; inport[0] = 32'h0;
      test_reset();
      test_preload();
      test_byte();
      test_half();
      test_misalign();
      test_outport();
      test_inport();
      test_flash_wins();
      test_back_to_back();
      test_reset_midload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
